// File: rtl/alu_word_seq_pkg.sv
// alu_word_seq_pkg: shared ALU opcode/function codes plus the command and
// state encodings used by the multi-byte ALU sequencer.
//   op_mne      : 8-bit ALU opcodes (opOTYPE selects the O-type function unit)
//   fn_mne      : O-type function codes driven on the ALU function port
//   seq_cmd_t   : wide command issued by the core control path
//   seq_state_t : sequencer FSM states
package alu_word_seq_pkg;

  localparam int ALU_W = 8;

  typedef enum logic [2:0] {
    opADD   = 3'd0,
    opSUB   = 3'd1,
    opAND   = 3'd2,
    opOR    = 3'd3,
    opXOR   = 3'd4,
    opPASS  = 3'd5,
    opCMP   = 3'd6,
    opOTYPE = 3'd7
  } op_mne;

  typedef enum logic [2:0] {
    fnSHIFTL_O = 3'd0,
    fnSHIFTR_O = 3'd1,
    fnROTL_O   = 3'd2,
    fnROTR_O   = 3'd3,
    fnNOT_O    = 3'd4,
    fnSWAP_O   = 3'd5,
    fnINC_O    = 3'd6,
    fnDEC_O    = 3'd7
  } fn_mne;

  typedef enum logic [1:0] {
    CMD_ADD = 2'd0,
    CMD_SUB = 2'd1,
    CMD_SHL = 2'd2,
    CMD_SHR = 2'd3
  } seq_cmd_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/alu_word_seq.sv
// alu_word_seq: runs ADD/SUB/SHL/SHR on operands up to 8*NBYTES bits by
// feeding the external 8-bit combinational ALU one byte per clock and
// chaining its carry/shift-out through an internal carry register.
// Ports:
//   clk, rst             clock, async active-high reset
//   start, cmd, len      command request (sampled in IDLE), op, bytes-1
//   a_in, b_in           operands, byte 0 = LSB (b_in unused for shifts)
//   busy, done           busy in RUN/DONE, one-cycle completion pulse
//   result, carry_out    result (bytes above len zero), final carry
//   alu_a/b/op/func      ALU operand, opcode and O-type function drive
//   alu_ov_in/flag_in    ALU carry/shift-in, flag input (tied 0)
//   alu_out, alu_ov_out  ALU result byte and carry/shift-out
module alu_word_seq
  import alu_word_seq_pkg::*;
#(
  parameter  int NBYTES = 4,
  localparam int LW     = $clog2(NBYTES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            cmd,
  input  logic [LW-1:0]         len,
  input  logic [8*NBYTES-1:0]   a_in,
  input  logic [8*NBYTES-1:0]   b_in,
  output logic                  busy,
  output logic                  done,
  output logic [8*NBYTES-1:0]   result,
  output logic                  carry_out,
  output logic [ALU_W-1:0]      alu_a,
  output logic [ALU_W-1:0]      alu_b,
  output logic [2:0]            alu_op,
  output logic [2:0]            alu_func,
  output logic                  alu_ov_in,
  output logic                  alu_flag_in,
  input  logic [ALU_W-1:0]      alu_out,
  input  logic                  alu_ov_out
);

  localparam logic [LW-1:0] LEN_MAX = LW'(NBYTES - 1);

  seq_state_t                     state;
  seq_cmd_t                       cmd_q;
  logic [LW-1:0]                  len_q;
  logic [LW-1:0]                  idx;
  logic                           cy;
  logic [NBYTES-1:0][ALU_W-1:0]   a_q;
  logic [NBYTES-1:0][ALU_W-1:0]   b_q;
  logic [NBYTES-1:0][ALU_W-1:0]   res_q;

  // With a non-power-of-two NBYTES the len field can encode lengths past the
  // last byte; clamp so idx stays inside the operand arrays.
  logic [LW-1:0] len_c;
  assign len_c = (len > LEN_MAX) ? LEN_MAX : len;

  // SHR walks MSB->LSB, everything else LSB->MSB.
  logic last;
  assign last = (cmd_q == CMD_SHR) ? (idx == '0) : (idx == len_q);

  assign busy        = (state != S_IDLE);
  assign result      = res_q;
  assign alu_flag_in = 1'b0;

  // ALU drive decodes straight from registered state so that an async reset
  // returns the ALU side to its idle values without waiting for a clock.
  always_comb begin
    alu_op    = opADD;
    alu_func  = '0;
    alu_a     = '0;
    alu_b     = '0;
    alu_ov_in = 1'b0;
    if (state == S_RUN) begin
      alu_a     = a_q[idx];
      alu_ov_in = cy;
      unique case (cmd_q)
        CMD_ADD: alu_b = b_q[idx];
        // Subtract as A + ~B + 1; the +1 is the initial cy.
        CMD_SUB: alu_b = ~b_q[idx];
        CMD_SHL: begin
          alu_op   = opOTYPE;
          alu_func = fnSHIFTL_O;
        end
        CMD_SHR: begin
          alu_op   = opOTYPE;
          alu_func = fnSHIFTR_O;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cmd_q     <= CMD_ADD;
      len_q     <= '0;
      idx       <= '0;
      cy        <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      carry_out <= 1'b0;
      done      <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_q       <= a_in;
            b_q       <= b_in;
            cmd_q     <= seq_cmd_t'(cmd);
            len_q     <= len_c;
            res_q     <= '0;
            carry_out <= 1'b0;
            idx       <= (seq_cmd_t'(cmd) == CMD_SHR) ? len_c : '0;
            cy        <= (seq_cmd_t'(cmd) == CMD_SUB);
            state     <= S_RUN;
          end
        end
        S_RUN: begin
          res_q[idx] <= alu_out;
          cy         <= alu_ov_out;
          if (last) begin
            carry_out <= alu_ov_out;
            done      <= 1'b1;
            state     <= S_DONE;
          end else if (cmd_q == CMD_SHR) begin
            idx <= idx - 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
